// File: rtl/mc14500_system_if.sv
// Program-load handshake between a loader (master) and the MC14500 system (slave).
interface mc14500_system_if #(
    parameter int DATA_WIDTH = 12
);
    logic                  load_start;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_ready;

    modport master (
        output load_start,
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_start,
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/mc14500_system.sv
// MC14500-style 1-bit controller: loadable program memory, return stack,
// memory-mapped input pins, output latches and scratch bits.
module mc14500_system #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = ADDR_WIDTH + 4,
    parameter int STACK_DEPTH  = 16,
    parameter int INPUT_SIZE   = 8,
    parameter int OUTPUT_SIZE  = 8,
    parameter int SCRATCH_SIZE = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    mc14500_system_if.slave         load_bus,
    input  logic                    run,
    input  logic                    step,
    input  logic [INPUT_SIZE-1:0]   input_pins,
    output logic [OUTPUT_SIZE-1:0]  output_pins,
    output logic [ADDR_WIDTH-1:0]   pc_o,
    output logic                    busy,
    output logic                    flag_o,
    output logic                    flag_f,
    output logic                    stack_err
);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PC_TWO = ADDR_WIDTH'(2);
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FETCH, S_EXEC, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOPO, OP_LD, OP_LDC, OP_AND, OP_ANDC, OP_OR, OP_ORC, OP_XNOR,
        OP_STO, OP_STOC, OP_IEN, OP_OEN, OP_JMP, OP_RTN, OP_SKZ, OP_NOPF
    } op_t;

    state_t state, state_n;

    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0]   ir;
    logic [ADDR_WIDTH-1:0]   stack [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0]   pc, pc_n, ptr, ptr_n, operand, pc_inc, stack_top;
    logic [SPW-1:0]          sp, sp_n, sp_dec;
    logic                    rr, rr_n, ien, ien_n, oen, oen_n, err_n;
    logic [OUTPUT_SIZE-1:0]  out_n;
    logic [SCRATCH_SIZE-1:0] scratch, scr_n;
    logic                    rd_bit, d, wr_bit, mem_we, fetch, push;
    op_t                     op;

    assign op        = op_t'(ir[ADDR_WIDTH +: 4]);
    assign operand   = ir[ADDR_WIDTH-1:0];
    assign pc_inc    = pc + PC_ONE;
    assign sp_dec    = sp - SP_ONE;
    assign stack_top = stack[sp_dec[SIW-1:0]];
    assign d         = rd_bit & ien;
    assign wr_bit    = (op == OP_STOC) ? ~rr : rr;

    assign pc_o               = pc;
    assign busy               = (state == S_FETCH) || (state == S_EXEC);
    assign load_bus.load_ready = (state == S_LOAD);

    // Read map: inputs, then output readback, then scratch; all-ones reads RR.
    always_comb begin
        rd_bit = (&operand) ? rr : 1'b0;
        for (int unsigned i = 0; i < INPUT_SIZE; i++)
            if (operand == ADDR_WIDTH'(i)) rd_bit = input_pins[i];
        for (int unsigned i = 0; i < OUTPUT_SIZE; i++)
            if (operand == ADDR_WIDTH'(INPUT_SIZE + i)) rd_bit = output_pins[i];
        for (int unsigned i = 0; i < SCRATCH_SIZE; i++)
            if (operand == ADDR_WIDTH'(INPUT_SIZE + OUTPUT_SIZE + i)) rd_bit = scratch[i];
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ptr_n   = ptr;
        sp_n    = sp;
        rr_n    = rr;
        ien_n   = ien;
        oen_n   = oen;
        out_n   = output_pins;
        scr_n   = scratch;
        err_n   = stack_err;
        mem_we  = 1'b0;
        fetch   = 1'b0;
        push    = 1'b0;
        flag_o  = 1'b0;
        flag_f  = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_bus.load_start) begin
                    state_n = S_LOAD;
                    ptr_n   = '0;
                end else if (run || step) begin
                    state_n = S_FETCH;
                end
            end
            S_LOAD: begin
                if (load_bus.load_valid) begin
                    mem_we = 1'b1;
                    ptr_n  = ptr + PC_ONE;
                end
                if (!load_bus.load_start) begin
                    state_n = S_IDLE;
                    pc_n    = '0;
                    rr_n    = 1'b0;
                    sp_n    = '0;
                end
            end
            S_FETCH: begin
                fetch   = 1'b1;
                state_n = S_EXEC;
            end
            S_EXEC: begin
                state_n = run ? S_FETCH : S_IDLE;
                pc_n    = pc_inc;
                case (op)
                    OP_NOPO: flag_o = 1'b1;
                    OP_LD:   rr_n = d;
                    OP_LDC:  rr_n = ~d;
                    OP_AND:  rr_n = rr & d;
                    OP_ANDC: rr_n = rr & ~d;
                    OP_OR:   rr_n = rr | d;
                    OP_ORC:  rr_n = rr | ~d;
                    OP_XNOR: rr_n = ~(rr ^ d);
                    OP_STO, OP_STOC: begin
                        if (oen) begin
                            for (int unsigned i = 0; i < OUTPUT_SIZE; i++)
                                if (operand == ADDR_WIDTH'(INPUT_SIZE + i)) out_n[i] = wr_bit;
                            for (int unsigned i = 0; i < SCRATCH_SIZE; i++)
                                if (operand == ADDR_WIDTH'(INPUT_SIZE + OUTPUT_SIZE + i))
                                    scr_n[i] = wr_bit;
                        end
                    end
                    OP_IEN: ien_n = rd_bit;
                    OP_OEN: oen_n = rd_bit;
                    OP_JMP: begin
                        if (sp == SP_FULL) begin
                            pc_n    = pc;
                            err_n   = 1'b1;
                            state_n = S_HALT;
                        end else begin
                            push = 1'b1;
                            sp_n = sp + SP_ONE;
                            pc_n = operand;
                        end
                    end
                    OP_RTN: begin
                        if (sp == '0) begin
                            pc_n    = pc;
                            err_n   = 1'b1;
                            state_n = S_HALT;
                        end else begin
                            sp_n = sp_dec;
                            pc_n = stack_top;
                        end
                    end
                    OP_SKZ: if (!rr) pc_n = pc + PC_TWO;
                    OP_NOPF: begin
                        flag_f = 1'b1;
                        pc_n   = '0;
                    end
                endcase
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            ptr         <= '0;
            sp          <= '0;
            rr          <= 1'b0;
            ien         <= 1'b1;
            oen         <= 1'b1;
            output_pins <= '0;
            scratch     <= '0;
            stack_err   <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            ptr         <= ptr_n;
            sp          <= sp_n;
            rr          <= rr_n;
            ien         <= ien_n;
            oen         <= oen_n;
            output_pins <= out_n;
            scratch     <= scr_n;
            stack_err   <= err_n;
        end
    end

    // Program memory and return stack carry no reset so contents survive it;
    // their enables derive from the async-reset state, so reset blocks writes.
    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr] <= load_bus.load_data;
        if (fetch)  ir <= mem[pc];
        if (push)   stack[sp[SIW-1:0]] <= pc_inc;
    end
endmodule
